// File: rtl/memory_cycle.sv
// Memory stage of the RV32I pipeline: word-addressed data memory, M/W pipeline register and writeback mux.
// Latency 1 cycle M->W; no backpressure (register loads every cycle while rst is low).
module memory_cycle #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ALU_ResultM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ResultW
);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] w_idx;
  logic          w_in_range;
  logic [31:0]   w_rdata;

  logic          r_reg_write;
  logic [1:0]    r_result_src;
  logic [4:0]    r_rd;
  logic [31:0]   r_pc_plus4;
  logic [31:0]   r_alu_result;
  logic [31:0]   r_read_data;

  // Byte-offset bits are dropped; any set bit above the word index means out of range.
  assign w_idx      = ALU_ResultM[AW+1:2];
  assign w_in_range = (ALU_ResultM[31:AW+2] == '0);
  assign w_rdata    = w_in_range ? r_mem[w_idx] : 32'h0;

  always_ff @(posedge clk) begin
    if (!rst && MemWriteM && w_in_range) begin
      r_mem[w_idx] <= WriteDataM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg_write  <= 1'b0;
      r_result_src <= 2'b00;
      r_rd         <= 5'd0;
      r_pc_plus4   <= 32'h0;
      r_alu_result <= 32'h0;
      r_read_data  <= 32'h0;
    end else begin
      r_reg_write  <= RegWriteM;
      r_result_src <= ResultSrcM;
      r_rd         <= RD_M;
      r_pc_plus4   <= PCPlus4M;
      r_alu_result <= ALU_ResultM;
      r_read_data  <= w_rdata;
    end
  end

  assign RegWriteW   = r_reg_write;
  assign ResultSrcW  = r_result_src;
  assign RD_W        = r_rd;
  assign PCPlus4W    = r_pc_plus4;
  assign ALU_ResultW = r_alu_result;
  assign ReadDataW   = r_read_data;

  always_comb begin
    ResultW = 32'h0;
    case (r_result_src)
      2'b00:   ResultW = r_alu_result;
      2'b01:   ResultW = r_read_data;
      2'b10:   ResultW = r_pc_plus4;
      default: ResultW = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle: vector table for the store/load/mux paths, hand sequences for reset.
module tb_memory_cycle;

  logic        clk, rst;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW, ResultW;

  int checks = 0;
  int errors = 0;

  memory_cycle #(.DEPTH(1024), .AW(10)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W), .PCPlus4W(PCPlus4W),
    .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .ResultW(ResultW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic        mw;
    logic [1:0]  src;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] wd;
    logic [31:0] alu;
    logic [31:0] e_rdata;
    logic [31:0] e_res;
  } vec_t;

  localparam int NV = 16;
  vec_t vec [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic rw, input logic [1:0] src, input logic [4:0] rd,
                       input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [31:0] res);
    chk({tag, ".RegWriteW"},   {31'b0, RegWriteW},  {31'b0, rw});
    chk({tag, ".ResultSrcW"},  {30'b0, ResultSrcW}, {30'b0, src});
    chk({tag, ".RD_W"},        {27'b0, RD_W},       {27'b0, rd});
    chk({tag, ".PCPlus4W"},    PCPlus4W,            pc);
    chk({tag, ".ALU_ResultW"}, ALU_ResultW,         alu);
    chk({tag, ".ReadDataW"},   ReadDataW,           rdata);
    chk({tag, ".ResultW"},     ResultW,             res);
  endtask

  task automatic drive(input logic rw, input logic mw, input logic [1:0] src, input logic [4:0] rd,
                       input logic [31:0] pc, input logic [31:0] wd, input logic [31:0] alu);
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = src; RD_M = rd;
    PCPlus4M = pc; WriteDataM = wd; ALU_ResultM = alu;
  endtask

  initial begin
    // Stores read the old word in their own cycle; loads see the word stored one cycle earlier.
    //          rw    mw    src    rd     pc            wd            alu           e_rdata       e_res
    vec[0]  = '{1'b0, 1'b1, 2'b00, 5'd0,  32'h0000_0104, 32'h1234_5678, 32'h0000_0042, 32'h0000_0000, 32'h0000_0042};
    vec[1]  = '{1'b1, 1'b0, 2'b01, 5'd3,  32'h0000_0108, 32'h0000_0000, 32'h0000_0040, 32'h1234_5678, 32'h1234_5678};
    vec[2]  = '{1'b0, 1'b1, 2'b00, 5'd0,  32'h0000_010C, 32'hDEAD_BEEF, 32'h0000_0040, 32'h1234_5678, 32'h0000_0040};
    vec[3]  = '{1'b1, 1'b0, 2'b01, 5'd5,  32'h0000_0110, 32'h0000_0000, 32'h0000_0040, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vec[4]  = '{1'b1, 1'b0, 2'b00, 5'd7,  32'h0000_0114, 32'hFFFF_FFFF, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0040};
    vec[5]  = '{1'b0, 1'b1, 2'b00, 5'd0,  32'h0000_0118, 32'h1111_2222, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vec[6]  = '{1'b0, 1'b1, 2'b00, 5'd0,  32'h0000_011C, 32'hAAAA_5555, 32'h0000_1000, 32'h0000_0000, 32'h0000_1000};
    vec[7]  = '{1'b1, 1'b0, 2'b01, 5'd6,  32'h0000_0120, 32'h0000_0000, 32'h0000_0000, 32'h1111_2222, 32'h1111_2222};
    vec[8]  = '{1'b1, 1'b0, 2'b01, 5'd6,  32'h0000_0124, 32'h0000_0000, 32'h0000_1000, 32'h0000_0000, 32'h0000_0000};
    vec[9]  = '{1'b0, 1'b1, 2'b00, 5'd0,  32'h0000_0128, 32'h0BAD_F00D, 32'h0000_0FFC, 32'h0000_0000, 32'h0000_0FFC};
    vec[10] = '{1'b1, 1'b0, 2'b01, 5'd31, 32'h0000_012C, 32'h0000_0000, 32'h0000_0FFC, 32'h0BAD_F00D, 32'h0BAD_F00D};
    vec[11] = '{1'b0, 1'b1, 2'b00, 5'd0,  32'h0000_0130, 32'h0000_0077, 32'h0000_0008, 32'h0000_0000, 32'h0000_0008};
    vec[12] = '{1'b1, 1'b0, 2'b00, 5'd0,  32'h0000_0059, 32'h0000_0000, 32'h0000_0055, 32'h0000_0000, 32'h0000_0055};
    vec[13] = '{1'b1, 1'b0, 2'b10, 5'd1,  32'h0000_0059, 32'h0000_0000, 32'h0000_0055, 32'h0000_0000, 32'h0000_0059};
    vec[14] = '{1'b1, 1'b0, 2'b11, 5'd2,  32'h0000_0059, 32'h0000_0000, 32'h0000_0055, 32'h0000_0000, 32'h0000_0000};
    vec[15] = '{1'b1, 1'b0, 2'b01, 5'd8,  32'h0000_0134, 32'h0000_0000, 32'h0000_0008, 32'h0000_0077, 32'h0000_0077};

    // Reset held with every input nonzero, including a store to 0x80.
    rst = 1'b1;
    drive(1'b1, 1'b1, 2'b10, 5'h1F, 32'h0000_1234, 32'hCAFE_0001, 32'h0000_0080);
    #1 chk_w("rst_t0", 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_w("rst_hold", 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    MemWriteM = 1'b0;
    @(posedge clk); #1;
    chk_w("rst_release", 1'b1, 2'b10, 5'h1F, 32'h0000_1234, 32'h0000_0080, 32'h0, 32'h0000_1234);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vec[i].rw, vec[i].mw, vec[i].src, vec[i].rd, vec[i].pc, vec[i].wd, vec[i].alu);
      @(posedge clk); #1;
      chk_w($sformatf("vec%0d", i), vec[i].rw, vec[i].src, vec[i].rd, vec[i].pc, vec[i].alu,
            vec[i].e_rdata, vec[i].e_res);
    end

    // Asynchronous reset in the middle of a store to 0x8.
    @(negedge clk);
    drive(1'b1, 1'b1, 2'b00, 5'd9, 32'h0000_0138, 32'h0000_0099, 32'h0000_0008);
    #2 rst = 1'b1;
    #1 chk_w("async_rst", 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk_w("async_rst_edge", 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 2'b01, 5'd4, 32'h0000_013C, 32'h0, 32'h0000_0008);
    @(posedge clk); #1;
    chk_w("post_rst_ld8", 1'b1, 2'b01, 5'd4, 32'h0000_013C, 32'h0000_0008, 32'h0000_0077, 32'h0000_0077);
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b01, 5'd5, 32'h0000_0140, 32'h0, 32'h0000_0040);
    @(posedge clk); #1;
    chk_w("post_rst_ld40", 1'b1, 2'b01, 5'd5, 32'h0000_0140, 32'h0000_0040, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
